// File: rtl/param_cpu_if.sv
// ROM, switch and LED-side signals of param_cpu, bundled as one port.
// master = CPU side, slave = board side (ROM, switches, LEDs).
interface param_cpu_if #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4
) ();
  logic [ADDR_W-1:0]   addr;
  logic [DATA_W+3:0]   data;
  logic [DATA_W-1:0]   in_port;
  logic [DATA_W-1:0]   out_port;
  logic                halted;

  modport master (
    output addr,
    output out_port,
    output halted,
    input  data,
    input  in_port
  );

  modport slave (
    input  addr,
    input  out_port,
    input  halted,
    output data,
    output in_port
  );
endinterface

// File: rtl/param_cpu.sv
// Single-cycle accumulator CPU: two registers, carry flag, instruction pointer
// into a combinational ROM, registered output port and a sticky halt state.
module param_cpu #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4
) (
  input  logic         clk,
  input  logic         n_reset,
  param_cpu_if.master  bus
);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  localparam logic [3:0] OP_ADD_A  = 4'b0000;
  localparam logic [3:0] OP_MOV_AB = 4'b0001;
  localparam logic [3:0] OP_IN_A   = 4'b0010;
  localparam logic [3:0] OP_MOV_AI = 4'b0011;
  localparam logic [3:0] OP_MOV_BA = 4'b0100;
  localparam logic [3:0] OP_ADD_B  = 4'b0101;
  localparam logic [3:0] OP_IN_B   = 4'b0110;
  localparam logic [3:0] OP_MOV_BI = 4'b0111;
  localparam logic [3:0] OP_HLT    = 4'b1000;
  localparam logic [3:0] OP_OUT_B  = 4'b1001;
  localparam logic [3:0] OP_OUT_I  = 4'b1011;
  localparam logic [3:0] OP_JNC    = 4'b1110;
  localparam logic [3:0] OP_JMP    = 4'b1111;

  // Low ADDR_W bits of the immediate, zero-extended when ADDR_W > DATA_W.
  function automatic logic [ADDR_W-1:0] jump_target(input logic [DATA_W-1:0] im);
    logic [ADDR_W+DATA_W-1:0] w_ext;
    w_ext = {{ADDR_W{1'b0}}, im};
    return w_ext[ADDR_W-1:0];
  endfunction

  state_t              r_state;
  state_t              w_state;
  logic [DATA_W-1:0]   r_a;
  logic [DATA_W-1:0]   r_b;
  logic [DATA_W-1:0]   r_out;
  logic                r_c;
  logic [ADDR_W-1:0]   r_ip;
  logic [DATA_W-1:0]   w_a;
  logic [DATA_W-1:0]   w_b;
  logic [DATA_W-1:0]   w_out;
  logic                w_c;
  logic [ADDR_W-1:0]   w_ip;

  logic [3:0]          w_op;
  logic [DATA_W-1:0]   w_im;
  logic [DATA_W:0]     w_sum_a;
  logic [DATA_W:0]     w_sum_b;
  logic [ADDR_W-1:0]   w_ip_inc;
  logic [ADDR_W-1:0]   w_target;

  assign w_op     = bus.data[DATA_W+3:DATA_W];
  assign w_im     = bus.data[DATA_W-1:0];
  assign w_sum_a  = {1'b0, r_a} + {1'b0, w_im};
  assign w_sum_b  = {1'b0, r_b} + {1'b0, w_im};
  assign w_ip_inc = r_ip + ADDR_W'(1);
  assign w_target = jump_target(w_im);

  // Decode and execute the fetched instruction; carry survives only an ADD.
  always_comb begin
    w_state = r_state;
    w_a     = r_a;
    w_b     = r_b;
    w_out   = r_out;
    w_c     = r_c;
    w_ip    = r_ip;
    case (r_state)
      ST_RUN: begin
        w_c  = 1'b0;
        w_ip = w_ip_inc;
        case (w_op)
          OP_ADD_A: begin
            w_a = w_sum_a[DATA_W-1:0];
            w_c = w_sum_a[DATA_W];
          end
          OP_ADD_B: begin
            w_b = w_sum_b[DATA_W-1:0];
            w_c = w_sum_b[DATA_W];
          end
          OP_MOV_AI: w_a = w_im;
          OP_MOV_BI: w_b = w_im;
          OP_MOV_AB: w_a = r_b;
          OP_MOV_BA: w_b = r_a;
          OP_IN_A:   w_a = bus.in_port;
          OP_IN_B:   w_b = bus.in_port;
          OP_OUT_B:  w_out = r_b;
          OP_OUT_I:  w_out = w_im;
          OP_JMP:    w_ip = w_target;
          OP_JNC: begin
            if (!r_c) begin
              w_ip = w_target;
            end else begin
              w_ip = w_ip_inc;
            end
          end
          OP_HLT: begin
            w_state = ST_HALT;
            w_ip    = r_ip;
            w_c     = r_c;
          end
          default: w_c = 1'b0;
        endcase
      end
      ST_HALT: w_state = ST_HALT;
      default: w_state = ST_RUN;
    endcase
  end

  // Architectural state; reset clears everything without needing a clock.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_state <= ST_RUN;
      r_a     <= {DATA_W{1'b0}};
      r_b     <= {DATA_W{1'b0}};
      r_out   <= {DATA_W{1'b0}};
      r_c     <= 1'b0;
      r_ip    <= {ADDR_W{1'b0}};
    end else begin
      r_state <= w_state;
      r_a     <= w_a;
      r_b     <= w_b;
      r_out   <= w_out;
      r_c     <= w_c;
      r_ip    <= w_ip;
    end
  end

  assign bus.addr     = r_ip;
  assign bus.out_port = r_out;
  assign bus.halted   = (r_state == ST_HALT);

endmodule

// File: doc/param_cpu.md
# param_cpu

Parametrised single-cycle accumulator CPU for the mother board; the multi-bit successor to the 1-bit NOT/NOP core. It fetches one instruction per clock from an external combinational ROM addressed by its instruction pointer. It holds two general registers and a carry flag, executes add/move/jump/input/output/halt, and drives a registered output port, normally wired to LEDs. Sits between the board ROM, the switch input and the LED bank.

## Interface
- DATA_W, 4: width of registers A, B, immediate, in_port, out_port (≥ 1)
- ADDR_W, 4: width of instruction pointer and ROM address (≥ 1)
- clk  in  1  system clock, all state updates on rising edge
- n_reset  in  1  asynchronous active-low reset
- addr  out  ADDR_W  ROM address; equals IP
- data  in  4+DATA_W  instruction word from ROM: [DATA_W+3:DATA_W] opcode, [DATA_W-1:0] immediate Im
- in_port  in  DATA_W  external input, sampled by IN instructions
- out_port  out  DATA_W  registered output port
- halted  out  1  high once HLT has executed

## Operation
- State: A, B, OUT (DATA_W each), C (1), IP (ADDR_W), H (1). addr = IP, out_port = OUT, halted = H.
- Jump target T = Im zero-extended or truncated to ADDR_W (low ADDR_W bits).
- Opcodes; unless stated otherwise, IP ← IP+1 mod 2^ADDR_W and C ← 0:
  - 0000 ADD A,Im: {C,A} ← A+Im, (DATA_W+1)-bit sum, C = carry out
  - 0101 ADD B,Im: {C,B} ← B+Im
  - 0011 MOV A,Im: A ← Im
  - 0111 MOV B,Im: B ← Im
  - 0001 MOV A,B: A ← B
  - 0100 MOV B,A: B ← A
  - 0010 IN A: A ← in_port
  - 0110 IN B: B ← in_port
  - 1001 OUT B: OUT ← B
  - 1011 OUT Im: OUT ← Im
  - 1111 JMP Im: IP ← T
  - 1110 JNC Im: IP ← T if C==0, else IP+1
  - 1000 HLT: H ← 1; IP, A, B, OUT, C hold
  - all other codes: NOP, with C ← 0
- While H=1: all state frozen, data ignored; only reset clears it.
- JNC tests C as written by the immediately preceding instruction. Any non-ADD instruction, including JNC itself, clears C.
- IP wraps 2^ADDR_W−1 → 0 without side effect.
- MOV A,B and MOV B,A read pre-edge values; no swap hazards.

## Timing
- Single cycle: addr valid from IP after clk edge; ROM is combinational, data sampled at next rising edge together with in_port.
- Every instruction completes in exactly 1 cycle; no stalls, no handshake.
- Reset: n_reset low asynchronously forces A=B=OUT=0, C=0, IP=0, H=0. So addr=0, out_port=0, halted=0 immediately, no clock needed. Reset mid-instruction discards it.
- Release: first edge with n_reset high executes ROM[0].
- out_port changes only on the edge that executes OUT; halted rises on the edge executing HLT.

## Test plan
- Reset mid-run (asynchronous assert between edges) -> addr, out_port, halted go 0 before next edge; after release, ROM[0] executes on first edge.
- DATA_W=4: MOV A,3; ADD A,14; JNC 7; OUT Im 5 -> A=1, C=1, jump not taken, IP=3, out_port=5 after 4 edges.
- ADD A,1 with A=0; JNC 0 -> C=0, IP=0 (taken). JNC right after MOV always taken.
- IN A (in_port=0xA); MOV B,A; OUT B -> out_port=0xA on 3rd edge; change in_port afterwards -> out_port unchanged.
- ADDR_W=4 straight-line NOPs -> addr 0..15 then 0 (wrap); JMP 9 with DATA_W=8, ADDR_W=3 -> IP=1.
- HLT at address 2 -> halted=1, addr stays 2 for 20 edges, out_port held; n_reset pulse -> halted=0, addr=0.
